// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// One quotient bit per cycle; stalls the pipeline while a division is in flight.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  input  logic             ex_hold,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       state_dbg
);

  // Handshake: div_start is a level held by EX for as long as div_stall is
  // high; div_stall drops in the DONE cycle, when div_done and the results are
  // valid, so the pipeline advances exactly once past the div. cancel overrides
  // everything and returns to IDLE without producing a result.

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   dvsr;
  logic [WIDTH-1:0] opa_raw;
  logic             sign_q;
  logic             sign_r;
  logic             dvz;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH:0]   mag_b;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   sub;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand magnitudes; the dividend magnitude of the most negative value
  // is still exact when read as unsigned.
  always_comb begin
    sa    = div_signed & opa[WIDTH-1];
    sb    = div_signed & opb[WIDTH-1];
    mag_a = sa ? (~opa + ONE) : opa;
    mag_b = {1'b0, (sb ? (~opb + ONE) : opb)};
  end

  // One restoring step. rem_sh[WIDTH] set means rem_sh already exceeds any
  // divisor; otherwise the top bit of the difference is the borrow.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    sub    = rem_sh - dvsr;
    ge     = rem_sh[WIDTH] | ~sub[WIDTH];
    rem_nx = ge ? sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ge};
  end

  // Sign fixup; divide by zero bypasses it and returns the raw dividend.
  always_comb begin
    q_fix = '1;
    r_fix = opa_raw;
    if (!dvz) begin
      q_fix = sign_q ? (~quo_nx + ONE) : quo_nx;
      r_fix = sign_r ? (~rem_nx + ONE) : rem_nx;
    end
  end

  always_comb begin
    div_stall = !cancel && (((state == S_IDLE) && div_start) || (state == S_CALC));
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      opa_raw   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dvz       <= 1'b0;
      div_done  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (cancel) begin
      state    <= S_IDLE;
      div_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_start) begin
            rem     <= '0;
            quo     <= mag_a;
            dvsr    <= mag_b;
            opa_raw <= opa;
            sign_q  <= sa ^ sb;
            sign_r  <= sa;
            dvz     <= (opb == '0);
            count   <= CNT_INIT;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          rem   <= rem_nx;
          quo   <= quo_nx;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            div_done  <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Held instruction stays in EX; do not restart it.
          if (!ex_hold) begin
            div_done <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          div_done <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, random operands
// against an arithmetic reference, and hand sequences for cancel/hold/reset.
module tb_div_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_start;
  logic         div_signed;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cancel;
  logic         ex_hold;
  logic         div_stall;
  logic         div_done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic [1:0]   state_dbg;

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .div_signed(div_signed),
    .opa       (opa),
    .opb       (opb),
    .cancel    (cancel),
    .ex_hold   (ex_hold),
    .div_stall (div_stall),
    .div_done  (div_done),
    .quotient  (quotient),
    .remainder (remainder),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc;
  int st;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   last_q;
  logic [W-1:0]   last_r;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with MIPS conventions.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint       la;
    longint       lb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = W'(la / lb);
      r  = W'(la % lb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Counts cycles from the current (start) cycle until div_done, bounded.
  task automatic wait_done(output int c, output int s);
    c = 0;
    s = 0;
    while (c < 60) begin
      #1;
      if (div_done) break;
      if (div_stall) s++;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic collect(input string name);
    logic [2*W-1:0] e;
    wait_done(cyc, st);
    check({name, "_latency"}, W'(cyc), W'(33));
    check({name, "_stall_cycles"}, W'(st), W'(33));
    check({name, "_stall_in_done"}, W'(div_stall), W'(0));
    e = exp_q.pop_front();
    check({name, "_q"}, quotient, e[2*W-1:W]);
    check({name, "_r"}, remainder, e[W-1:0]);
    last_q = e[2*W-1:W];
    last_r = e[W-1:0];
  endtask

  // driver: one full division with the instruction leaving EX after DONE
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input string name);
    @(negedge clk);
    opa = a;
    opb = b;
    div_signed = s;
    div_start = 1'b1;
    collect(name);
    div_start = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_done_drop"}, W'(div_done), W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;

    vt[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vt[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vt[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    vt[3] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
    vt[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vt[5] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    vt[6] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9};
    vt[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
    vt[8] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF};

    rst = 1'b1;
    div_start = 1'b0;
    div_signed = 1'b0;
    opa = '0;
    opb = '0;
    cancel = 1'b0;
    ex_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_done", W'(div_done), W'(0));
    check("rst_q", quotient, W'(0));
    check("rst_r", remainder, W'(0));
    check("rst_stall", W'(div_stall), W'(0));

    // start and cancel together: stall suppressed, start ignored
    opa = 32'd50;
    opb = 32'd5;
    div_start = 1'b1;
    #1;
    check("idle_start_stall", W'(div_stall), W'(1));
    cancel = 1'b1;
    #1;
    check("start_cancel_stall", W'(div_stall), W'(0));
    @(negedge clk);
    cancel = 1'b0;
    div_start = 1'b0;
    #1;
    check("start_cancel_after", W'(div_stall), W'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (div_done) seen++;
    end
    check("start_cancel_no_done", W'(seen), W'(0));

    // directed vectors
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({vt[i].q, vt[i].r});
      do_div(vt[i].a, vt[i].b, vt[i].s, $sformatf("vec%0d", i));
    end

    // random operands against the reference
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      s = 1'(($urandom_range(0, 1)));
      if (sel == 0) b = '0;
      else if (sel < 5) b = W'($urandom_range(1, 300));
      else b = $urandom;
      if (sel == 1) b = -b;
      exp_q.push_back(ref_div(a, b, s));
      do_div(a, b, s, $sformatf("rnd%0d", i));
    end

    // cancel on the 10th CALC cycle
    @(negedge clk);
    opa = 32'd1000;
    opb = 32'd3;
    div_signed = 1'b0;
    div_start = 1'b1;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel_stall_same", W'(div_stall), W'(0));
    @(negedge clk);
    cancel = 1'b0;
    div_start = 1'b0;
    #1;
    check("cancel_stall_next", W'(div_stall), W'(0));
    check("cancel_done", W'(div_done), W'(0));
    check("cancel_keep_q", quotient, last_q);
    check("cancel_keep_r", remainder, last_r);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (div_done) seen++;
    end
    check("cancel_no_done", W'(seen), W'(0));
    exp_q.push_back({32'd3, 32'd0});
    do_div(32'd9, 32'd3, 1'b0, "after_cancel");

    // ex_hold in DONE with div_start still high
    @(negedge clk);
    opa = 32'd100;
    opb = 32'd7;
    div_signed = 1'b0;
    div_start = 1'b1;
    exp_q.push_back({32'd14, 32'd2});
    collect("hold");
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold_done%0d", i), W'(div_done), W'(1));
      check($sformatf("hold_q%0d", i), quotient, W'(14));
      check($sformatf("hold_r%0d", i), remainder, W'(2));
      check($sformatf("hold_stall%0d", i), W'(div_stall), W'(0));
    end
    ex_hold = 1'b0;
    opa = 32'd9;
    opb = 32'd3;
    @(negedge clk);
    #1;
    check("hold_release_done", W'(div_done), W'(0));
    check("hold_release_stall", W'(div_stall), W'(1));
    exp_q.push_back(ref_div(32'd9, 32'd3, 1'b0));
    collect("after_hold");
    div_start = 1'b0;
    @(negedge clk);

    // back-to-back: second start lands 34 cycles after the first
    @(negedge clk);
    opa = 32'd1000;
    opb = 32'd10;
    div_signed = 1'b0;
    div_start = 1'b1;
    exp_q.push_back(ref_div(32'd1000, 32'd10, 1'b0));
    collect("b2b_a");
    opa = 32'hFFFF_FF00;
    opb = 32'd16;
    div_signed = 1'b1;
    exp_q.push_back({32'hFFFF_FFF0, 32'd0});
    @(negedge clk);
    #1;
    check("b2b_gap_done", W'(div_done), W'(0));
    check("b2b_restart_stall", W'(div_stall), W'(1));
    collect("b2b_b");
    div_start = 1'b0;
    @(negedge clk);

    // asynchronous reset mid-CALC
    @(negedge clk);
    opa = 32'd1000;
    opb = 32'd7;
    div_signed = 1'b0;
    div_start = 1'b1;
    repeat (5) @(negedge clk);
    div_start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_done", W'(div_done), W'(0));
    check("arst_q", quotient, W'(0));
    check("arst_r", remainder, W'(0));
    check("arst_stall", W'(div_stall), W'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(ref_div(32'd77, 32'd5, 1'b0));
    do_div(32'd77, 32'd5, 1'b0, "after_arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
